// File: rtl/gate_resp_checker.sv
// gate_resp_checker: response-side checker for the combinational gate blocks.
// Optional MISR signature over every accepted beat: define GATE_CHK_MISR_EN.
module gate_resp_checker #(
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0]       num_vec,
  input  logic             in_valid,
  input  logic [2:0]       in_stim,
  input  logic [4:0]       in_resp,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [7:0]       first_err_idx,
  output logic [4:0]       first_err_mask,
  output logic [15:0]      sig
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [ERR_W-1:0] ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic             r_in_ready;
  logic             r_busy;
  logic             r_done;
  logic [7:0]       r_num;
  logic [7:0]       r_idx;
  logic [ERR_W-1:0] r_err;
  logic [7:0]       r_fidx;
  logic [4:0]       r_fmask;

  logic       w_a;
  logic       w_b;
  logic       w_c;
  logic [4:0] w_exp;
  logic [4:0] w_mask;
  logic       w_mis;
  logic       w_acc;
  logic       w_last;
  logic       w_sat;
  logic       w_start;

  assign w_a     = in_stim[2];
  assign w_b     = in_stim[1];
  assign w_c     = in_stim[0];
  assign w_exp   = { w_a & w_b & w_c,
                     w_a | w_b | w_c,
                     ~(w_a & w_b & w_c),
                     ~(w_a | w_b | w_c),
                     w_a ^ w_b ^ w_c };
  assign w_mask  = w_exp ^ in_resp;
  assign w_mis   = |w_mask;
  assign w_acc   = in_valid & r_in_ready;
  assign w_last  = (r_idx == (r_num - 8'd1));
  assign w_sat   = &r_err;
  assign w_start = start & (r_state != S_RUN);

  // Run control, beat counting and first-failure capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_num      <= 8'd0;
      r_idx      <= 8'd0;
      r_err      <= '0;
      r_fidx     <= 8'd0;
      r_fmask    <= 5'd0;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_num   <= num_vec;
            r_idx   <= 8'd0;
            r_err   <= '0;
            r_fidx  <= 8'd0;
            r_fmask <= 5'd0;
            if (num_vec == 8'd0) begin
              r_state    <= S_DONE;
              r_done     <= 1'b1;
              r_busy     <= 1'b0;
              r_in_ready <= 1'b0;
            end else begin
              r_state    <= S_RUN;
              r_done     <= 1'b0;
              r_busy     <= 1'b1;
              r_in_ready <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (w_acc) begin
            r_idx <= r_idx + 8'd1;
            if (w_mis) begin
              if (!w_sat) begin
                r_err <= r_err + ERR_ONE;
              end
              if (r_err == '0) begin
                r_fidx  <= r_idx;
                r_fmask <= w_mask;
              end
            end
            if (w_last) begin
              r_state    <= S_DONE;
              r_done     <= 1'b1;
              r_busy     <= 1'b0;
              r_in_ready <= 1'b0;
            end
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_done     <= 1'b0;
          r_busy     <= 1'b0;
          r_in_ready <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready       = r_in_ready;
  assign busy           = r_busy;
  assign done           = r_done;
  assign pass           = r_done & (r_err == '0);
  assign err_cnt        = r_err;
  assign first_err_idx  = r_fidx;
  assign first_err_mask = r_fmask;

`ifdef GATE_CHK_MISR_EN
  logic [15:0] r_sig;

  // CRC-16-CCITT style MISR folding {stim,resp} of each accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sig <= 16'h0000;
    end else if (w_start) begin
      r_sig <= 16'hFFFF;
    end else if (w_acc) begin
      r_sig <= {r_sig[14:0], 1'b0}
             ^ (r_sig[15] ? 16'h1021 : 16'h0000)
             ^ {8'h00, in_stim, in_resp};
    end
  end

  assign sig = r_sig;
`else
  logic w_unused;
  assign w_unused = w_start;
  assign sig      = 16'h0000;
`endif

endmodule

// File: tb/tb_gate_resp_checker.sv
// tb_gate_resp_checker: table-driven checker runs with a per-run scoreboard.
// A second instance with ERR_W=2 shares all stimulus to cover saturation.
module tb_gate_resp_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  num_vec = 8'd0;
  logic        in_valid = 1'b0;
  logic [2:0]  in_stim = 3'd0;
  logic [4:0]  in_resp = 5'd0;

  logic        in_ready, busy, done, pass;
  logic [7:0]  err_cnt, first_err_idx;
  logic [4:0]  first_err_mask;
  logic [15:0] sig;

  logic        s_in_ready, s_busy, s_done, s_pass;
  logic [1:0]  s_err_cnt;
  logic [7:0]  s_first_err_idx;
  logic [4:0]  s_first_err_mask;
  logic [15:0] s_sig;

  gate_resp_checker #(.ERR_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_vec(num_vec),
    .in_valid(in_valid), .in_stim(in_stim), .in_resp(in_resp),
    .in_ready(in_ready), .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .first_err_idx(first_err_idx),
    .first_err_mask(first_err_mask), .sig(sig)
  );

  gate_resp_checker #(.ERR_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .num_vec(num_vec),
    .in_valid(in_valid), .in_stim(in_stim), .in_resp(in_resp),
    .in_ready(s_in_ready), .busy(s_busy), .done(s_done), .pass(s_pass),
    .err_cnt(s_err_cnt), .first_err_idx(s_first_err_idx),
    .first_err_mask(s_first_err_mask), .sig(s_sig)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] stim;
    logic [4:0] resp;
    logic [4:0] mask;
  } beat_t;

  typedef struct packed {
    logic [7:0] err8;
    logic [1:0] err2;
    logic [7:0] fidx;
    logic [4:0] fmask;
    logic       pass;
  } exp_t;

  beat_t tbl[12];
  exp_t  sbq[$];
  int    q[$];
  int    tests = 0;
  int    fails = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Runs the beats listed in q; caller is positioned #1 after a posedge.
  task automatic do_run(input bit gaps);
    exp_t e;
    int   n;
    e = '0;
    n = 0;
    foreach (q[i]) begin
      if (tbl[q[i]].mask != 5'd0) begin
        if (n == 0) begin
          e.fidx  = 8'(i);
          e.fmask = tbl[q[i]].mask;
        end
        n++;
      end
    end
    e.err8 = (n > 255) ? 8'd255 : 8'(n);
    e.err2 = (n > 3) ? 2'd3 : 2'(n);
    e.pass = (n == 0);
    sbq.push_back(e);
    start   = 1'b1;
    num_vec = 8'(q.size());
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_rise", {31'd0, busy}, 32'd1);
    chk("ready_rise", {31'd0, in_ready}, 32'd1);
    foreach (q[i]) begin
      if (gaps) begin
        in_valid = 1'b0;
        in_stim  = 3'b111;
        in_resp  = 5'b00000;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_stim  = tbl[q[i]].stim;
      in_resp  = tbl[q[i]].resp;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("done_after_last", {31'd0, done}, 32'd1);
    chk("ready_fall", {31'd0, in_ready}, 32'd0);
    chk("busy_fall", {31'd0, busy}, 32'd0);
    if (sbq.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      e = sbq.pop_front();
      chk("err_cnt", {24'd0, err_cnt}, {24'd0, e.err8});
      chk("first_err_idx", {24'd0, first_err_idx}, {24'd0, e.fidx});
      chk("first_err_mask", {27'd0, first_err_mask}, {27'd0, e.fmask});
      chk("pass", {31'd0, pass}, {31'd0, e.pass});
      chk("sat_err_cnt", {30'd0, s_err_cnt}, {30'd0, e.err2});
      chk("sat_first_idx", {24'd0, s_first_err_idx}, {24'd0, e.fidx});
      chk("sat_pass", {31'd0, s_pass}, {31'd0, e.pass});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{3'b101, 5'b01100, 5'b00000};
    tbl[1]  = '{3'b010, 5'b01101, 5'b00000};
    tbl[2]  = '{3'b001, 5'b01101, 5'b00000};
    tbl[3]  = '{3'b111, 5'b11001, 5'b00000};
    tbl[4]  = '{3'b000, 5'b00110, 5'b00000};
    tbl[5]  = '{3'b001, 5'b01111, 5'b00010};
    tbl[6]  = '{3'b000, 5'b00000, 5'b00110};
    tbl[7]  = '{3'b110, 5'b01100, 5'b00000};
    tbl[8]  = '{3'b011, 5'b11101, 5'b10001};
    tbl[9]  = '{3'b100, 5'b01101, 5'b00000};
    tbl[10] = '{3'b111, 5'b00000, 5'b11001};
    tbl[11] = '{3'b100, 5'b01001, 5'b00100};

    #1;
    chk("rst_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_pass", {31'd0, pass}, 32'd0);
    chk("rst_err", {24'd0, err_cnt}, 32'd0);
    chk("rst_fidx", {24'd0, first_err_idx}, 32'd0);
    chk("rst_fmask", {27'd0, first_err_mask}, 32'd0);
    chk("rst_sig", {16'd0, sig}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_ready", {31'd0, in_ready}, 32'd0);

    q = '{0, 1, 2, 3, 4};
    do_run(1'b0);

    in_valid = 1'b1;
    in_stim  = 3'b111;
    in_resp  = 5'b00000;
    repeat (3) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("hold_done", {31'd0, done}, 32'd1);
    chk("hold_err", {24'd0, err_cnt}, 32'd0);

    q = '{0, 1, 5, 3, 4};
    do_run(1'b0);

    q = '{6, 6, 6, 6, 6, 6};
    do_run(1'b0);

    start   = 1'b1;
    num_vec = 8'd0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("zero_ready_1", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    chk("zero_ready_2", {31'd0, in_ready}, 32'd0);
    chk("zero_done", {31'd0, done}, 32'd1);
    chk("zero_err_clr", {24'd0, err_cnt}, 32'd0);
    chk("zero_pass", {31'd0, pass}, 32'd1);

    q = '{7, 8, 9, 11};
    do_run(1'b1);

    start   = 1'b1;
    num_vec = 8'd5;
    @(posedge clk); #1;
    start    = 1'b0;
    in_valid = 1'b1;
    in_stim  = tbl[10].stim;
    in_resp  = tbl[10].resp;
    @(posedge clk); #1;
    in_stim = tbl[1].stim;
    in_resp = tbl[1].resp;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("abort_err", {24'd0, err_cnt}, 32'd1);
    chk("abort_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_err", {24'd0, err_cnt}, 32'd0);
    chk("mid_rst_fmask", {27'd0, first_err_mask}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_idle", {31'd0, in_ready}, 32'd0);
    q = '{3};
    do_run(1'b0);

    q = '{0};
    do_run(1'b0);
`ifdef GATE_CHK_MISR_EN
    chk("misr_sig", {16'd0, sig}, 32'h0000EF73);
`else
    chk("misr_sig", {16'd0, sig}, 32'h00000000);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
